anita3_trigger_pattern_buffer: RTL
==================================

// Module: anita3_trigger_pattern_buffer
// PURPOSE
//  Consumer of the simple-trigger outputs (trig, phi pattern, holdoff count).
//  On each trigger, captures the 2*NUM_PHI phi pattern plus metadata into a small FIFO.
//  Metadata: event number, holdoff count, optional timestamp.
//  Presents FIFO entries to the readout side through a valid/ready pop interface.
//  Everything runs on the 250 MHz trigger clock, between the trigger and the readout/event builder.
// PARAMETERS
//  NUM_PHI     16  phi sectors per polarization; pattern width is 2*NUM_PHI.
//  DEPTH_LOG2  3   log2 of FIFO depth (8 entries).
//  EVN_BITS    16  event number width.
//  TS_BITS     24  timestamp width (only with ANITA3_TRIG_BUF_TIMESTAMP_EN).
// PORTS
//  clk250_i     in   1          250 MHz trigger clock; only clock.
//  rst_n_i      in   1          asynchronous active-low reset.
//  trig_i       in   1          trigger from the simple trigger; pulse or level.
//  phi_i        in   2*NUM_PHI  phi pattern {H,V}; valid in the cycle trig_i rises.
//  count_i      in   8          holdoff-window trigger count; sampled with phi_i.
//  rd_i         in   1          pop request from readout.
//  valid_o      out  1          head entry is present on the data outputs.
//  phi_o        out  2*NUM_PHI  head entry pattern.
//  count_o      out  8          head entry count.
//  evnum_o      out  EVN_BITS   head entry event number.
//  timestamp_o  out  TS_BITS    head entry timestamp; 0 when the feature is compiled out.
//  full_o       out  1          FIFO holds 2**DEPTH_LOG2 entries.
//  overflow_o   out  1          sticky: at least one trigger was dropped.
//  dropped_o    out  8          count of dropped triggers; saturates at 255.
// BEHAVIOUR
//  Reset (async, rst_n_i=0): all outputs are 0; FIFO is empty.
//    Event number, timestamp, drop counter and edge-detect register are cleared.
//  Trigger detect: trig_q <= trig_i; write strobe wr = trig_i & !trig_q.
//    A trig_i held high for N cycles produces exactly one capture.
//  Every wr increments evn_ctr (wraps mod 2**EVN_BITS), whether accepted or dropped.
//    The captured event number is the pre-increment value, so the first event is 0.
//    Gaps in evnum_o therefore expose drops.
//  Write accepted if !full, or if a pop occurs in the same cycle.
//    A simultaneous write and pop on a full FIFO keeps it full and loses nothing.
//  Write rejected (full, no pop): entry is discarded; overflow_o <= 1 (sticky until reset).
//    dropped_o increments, saturating at 8'hFF.
//  Read side is first-word-fall-through; pop = rd_i & valid_o; rd_i while !valid_o is ignored.
//    After a pop, the next entry (if any) appears the following cycle and valid_o stays high.
//  Write-to-output latency: an entry written into an empty FIFO at edge k gives valid_o=1
//    with its data after edge k+1 (registered output stage).
//  Occupancy counter is DEPTH_LOG2+1 bits; pointers wrap mod 2**DEPTH_LOG2.
//    full_o is registered and equals (occupancy == 2**DEPTH_LOG2).
//  Data outputs hold the last value while valid_o=0; they are don't-care to the consumer.
//  Reset mid-operation: FIFO contents are lost, and valid_o/full_o/overflow_o drop immediately.
// CONFIGURATION
//  ANITA3_TRIG_BUF_TIMESTAMP_EN defined:
//    a free-running TS_BITS counter (wraps) is sampled by wr and stored per entry.
//    timestamp_o shows the head entry's timestamp.
//  Not defined: no counter and no timestamp storage; timestamp_o is constant 0.
// TESTING
//  1. Reset, then trig_i 1-cycle pulse with phi_i=32'h0003_0180, count_i=8'd2
//     -> two cycles later valid_o=1, phi_o=32'h0003_0180, count_o=2, evnum_o=0.
//  2. trig_i held high for 10 cycles -> exactly one entry; evnum counter advances by 1.
//  3. 8 pulses with no reads -> full_o=1.
//     A 9th pulse -> overflow_o=1, dropped_o=1.
//     Then pop 8 entries -> evnum 0..7 in order; the 9th (evnum 8) is absent.
//  4. FIFO full, trig_i edge in the same cycle as rd_i=1 -> full_o stays 1, overflow_o stays 0,
//     and the new entry is read out last.
//  5. rd_i=1 on an empty FIFO -> no state change.
//     300 drops -> dropped_o=255 (saturated).
//  6. With ANITA3_TRIG_BUF_TIMESTAMP_EN: pulses 100 cycles apart
//     -> timestamp_o difference between the two entries is 100.
//     Without it: timestamp_o=0 throughout.
//     Assert rst_n_i mid-stream -> valid_o=0 and full_o=0 immediately.

Source files
------------

// File: rtl/anita3_trigger_pattern_buffer.sv
// rtl/anita3_trigger_pattern_buffer.sv - trigger phi-pattern capture FIFO with FWFT pop interface
//
// Captures the {H,V} phi pattern, holdoff count and event number on each rising
// edge of trig_i into a 2**DEPTH_LOG2 entry FIFO and presents the head entry on
// a registered first-word-fall-through output stage.
//
// Optional feature macro: ANITA3_TRIG_BUF_TIMESTAMP_EN
//   defined   : free-running TS_BITS counter sampled per entry, shown on timestamp_o
//   undefined : no timestamp storage, timestamp_o is constant 0
//
// Ports:
//   clk250_i    - 250 MHz trigger clock
//   rst_n_i     - asynchronous active-low reset
//   trig_i      - trigger (pulse or level), rising edge captures
//   phi_i       - phi pattern, sampled on the trig_i rising cycle
//   count_i     - holdoff trigger count, sampled with phi_i
//   rd_i        - pop request; ignored while valid_o is low
//   valid_o     - head entry present on phi_o/count_o/evnum_o/timestamp_o
//   full_o      - FIFO holds 2**DEPTH_LOG2 entries
//   overflow_o  - sticky, at least one trigger was dropped
//   dropped_o   - dropped trigger count, saturating at 255
module anita3_trigger_pattern_buffer #(
    parameter int NUM_PHI    = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int EVN_BITS   = 16,
    parameter int TS_BITS    = 24
) (
    input  logic                   clk250_i,
    input  logic                   rst_n_i,
    input  logic                   trig_i,
    input  logic [2*NUM_PHI-1:0]   phi_i,
    input  logic [7:0]             count_i,
    input  logic                   rd_i,
    output logic                   valid_o,
    output logic [2*NUM_PHI-1:0]   phi_o,
    output logic [7:0]             count_o,
    output logic [EVN_BITS-1:0]    evnum_o,
    output logic [TS_BITS-1:0]     timestamp_o,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic [7:0]             dropped_o
);
    localparam int PHI_W = 2 * NUM_PHI;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
`ifdef ANITA3_TRIG_BUF_TIMESTAMP_EN
    localparam int ENTRY_W = PHI_W + 8 + EVN_BITS + TS_BITS;
`else
    localparam int ENTRY_W = PHI_W + 8 + EVN_BITS;
`endif

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0]         CNT_ONE  = 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [EVN_BITS-1:0]   EVN_ONE  = 1;

    logic                  trig_q, trig_d;
    logic [EVN_BITS-1:0]   evn_q, evn_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  valid_q, valid_d;
    logic [ENTRY_W-1:0]    head_q, head_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            dropped_q, dropped_d;
    logic [ENTRY_W-1:0]    mem_q [DEPTH];

    logic                  wr, pop, wr_acc;
    logic [CW-1:0]         cnt_after_pop;
    logic [ENTRY_W-1:0]    wr_entry;

`ifdef ANITA3_TRIG_BUF_TIMESTAMP_EN
    localparam logic [TS_BITS-1:0] TS_ONE = 1;
    logic [TS_BITS-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + TS_ONE;
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) ts_q <= '0;
        else          ts_q <= ts_d;
    end

    assign wr_entry    = {ts_q, evn_q, count_i, phi_i};
    assign timestamp_o = head_q[PHI_W+8+EVN_BITS +: TS_BITS];
`else
    assign wr_entry    = {evn_q, count_i, phi_i};
    assign timestamp_o = '0;
`endif

    always_comb begin
        trig_d     = trig_i;
        wr         = trig_i & ~trig_q;
        pop        = rd_i & valid_q;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        wr_acc     = wr & (~full_q | pop);
        evn_d      = wr ? evn_q + EVN_ONE : evn_q;
        wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q | (wr & ~wr_acc);
        dropped_d  = dropped_q;
        if (wr && !wr_acc && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;

        cnt_d = cnt_q;
        if (wr_acc && !pop)      cnt_d = cnt_q + CNT_ONE;
        else if (!wr_acc && pop) cnt_d = cnt_q - CNT_ONE;
        full_d = (cnt_d == CNT_FULL);

        // Output stage looks only at entries already in memory (pre-write count),
        // which gives the one-cycle registered write-to-output latency.
        cnt_after_pop = pop ? cnt_q - CNT_ONE : cnt_q;
        valid_d       = (cnt_after_pop != '0);
        head_d        = valid_d ? mem_q[rd_ptr_d] : head_q;
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q     <= 1'b0;
            evn_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            trig_q     <= trig_d;
            evn_q      <= evn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Storage needs no reset: occupancy and valid gate every read.
    always_ff @(posedge clk250_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign valid_o    = valid_q;
    assign phi_o      = head_q[PHI_W-1:0];
    assign count_o    = head_q[PHI_W +: 8];
    assign evnum_o    = head_q[PHI_W+8 +: EVN_BITS];
    assign full_o     = full_q;
    assign overflow_o = overflow_q;
    assign dropped_o  = dropped_q;
endmodule
